sr_latch_sequencer: RTL and testbench

Synchronous command sequencer that drives the active-low preset/clear vectors of the cross-coupled NAND set/reset latch array (WIDE+1 latches, bits numbered 1..WIDE+1). It accepts one set/reset command at a time over a valid/ready handshake. It issues a single-bit active-low pulse of fixed width and waits a settle interval. It then reads back q/qbar of the addressed latch and reports done and any error. It sits directly upstream of the latch array; q/qbar are fed back from the array outputs.

---
 rtl/sr_latch_sequencer.sv | 174 +++++++++++++++++
 tb/tb_sr_latch_sequencer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sr_latch_sequencer.sv
// Command sequencer for a NAND set/reset latch array: issues one active-low
// preset/clear pulse per accepted command, waits for settling, then verifies the latch.
module sr_latch_sequencer #(
  parameter int WIDE   = 17,
  parameter int IDXW   = 5,
  parameter int PULSE  = 2,
  parameter int SETTLE = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [IDXW-1:0]  cmd_idx,
  input  logic             cmd_val,
  output logic [WIDE+1:1]  preset,
  output logic [WIDE+1:1]  clear,
  input  logic [1:WIDE+1]  q_in,
  input  logic [1:WIDE+1]  qbar_in,
  output logic             done,
  output logic             err,
  output logic [1:0]       err_code
);

  localparam int N    = WIDE + 1;
  localparam int CMAX = (PULSE > SETTLE) ? PULSE : SETTLE;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [IDXW-1:0] MAXIDX = IDXW'(N);

  typedef enum logic [1:0] {S_IDLE, S_PULSE, S_SETTLE, S_CHECK} state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [IDXW-1:0] idx_reg, idx_next;
  logic            val_reg, val_next;
  logic [N:1]      preset_reg, preset_next;
  logic [N:1]      clear_reg, clear_next;
  logic            ready_reg, ready_next;
  logic            done_reg, done_next;
  logic            err_reg, err_next;
  logic [1:0]      code_reg, code_next;

  logic            accept;
  logic            idx_legal;
  logic            drive_low;
  logic            pulse_val;
  logic [IDXW-1:0] pulse_idx;
  logic [N:1]      sel_vec;

  assign accept    = cmd_valid & ready_reg;
  assign idx_legal = (cmd_idx != '0) && (cmd_idx <= MAXIDX);

  // In IDLE the bit being pulsed comes straight from the command; afterwards from the capture.
  assign pulse_idx = (state_reg == S_IDLE) ? cmd_idx : idx_reg;
  assign pulse_val = (state_reg == S_IDLE) ? cmd_val : val_reg;

  genvar gi;
  generate
    for (gi = 1; gi <= N; gi++) begin : g_sel
      assign sel_vec[gi] = (pulse_idx == IDXW'(gi));
    end
  endgenerate

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    idx_next    = idx_reg;
    val_next    = val_reg;
    preset_next = '1;
    clear_next  = '1;
    ready_next  = 1'b0;
    done_next   = 1'b0;
    err_next    = 1'b0;
    code_next   = 2'b00;
    drive_low   = 1'b0;

    case (state_reg)
      S_IDLE: begin
        ready_next = 1'b1;
        if (accept) begin
          ready_next = 1'b0;
          idx_next   = cmd_idx;
          val_next   = cmd_val;
          if (idx_legal) begin
            state_next = S_PULSE;
            cnt_next   = CW'(PULSE - 1);
            drive_low  = 1'b1;
          end else begin
            state_next = S_CHECK;
            done_next  = 1'b1;
            err_next   = 1'b1;
            code_next  = 2'b10;
          end
        end
      end
      S_PULSE: begin
        if (cnt_reg == '0) begin
          state_next = S_SETTLE;
          cnt_next   = CW'(SETTLE - 1);
        end else begin
          cnt_next  = cnt_reg - CW'(1);
          drive_low = 1'b1;
        end
      end
      S_SETTLE: begin
        if (cnt_reg == '0) begin
          // Feedback is captured on the edge entering CHECK so done/err leave as registers.
          state_next = S_CHECK;
          done_next  = 1'b1;
          if (q_in[idx_reg] == qbar_in[idx_reg]) begin
            err_next  = 1'b1;
            code_next = 2'b11;
          end else if (q_in[idx_reg] != val_reg) begin
            err_next  = 1'b1;
            code_next = 2'b01;
          end
        end else begin
          cnt_next = cnt_reg - CW'(1);
        end
      end
      S_CHECK: begin
        state_next = S_IDLE;
        ready_next = 1'b1;
      end
      default: state_next = S_IDLE;
    endcase

    if (drive_low) begin
      if (pulse_val) preset_next = ~sel_vec;
      else           clear_next  = ~sel_vec;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= S_IDLE;
      cnt_reg    <= '0;
      idx_reg    <= '0;
      val_reg    <= 1'b0;
      preset_reg <= '1;
      clear_reg  <= '1;
      ready_reg  <= 1'b0;
      done_reg   <= 1'b0;
      err_reg    <= 1'b0;
      code_reg   <= 2'b00;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      idx_reg    <= idx_next;
      val_reg    <= val_next;
      preset_reg <= preset_next;
      clear_reg  <= clear_next;
      ready_reg  <= ready_next;
      done_reg   <= done_next;
      err_reg    <= err_next;
      code_reg   <= code_next;
    end
  end

  assign preset    = preset_reg;
  assign clear     = clear_reg;
  assign cmd_ready = ready_reg;
  assign done      = done_reg;
  assign err       = err_reg;
  assign err_code  = code_reg;

  // Drive-safety invariants on the array control vectors.
  a_single_low: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(~(preset_reg & clear_reg)));
  a_no_both_low: assert property (@(posedge clk) disable iff (!rst_n)
    ((~preset_reg & ~clear_reg) == '0));
  a_low_only_in_pulse: assert property (@(posedge clk) disable iff (!rst_n)
    (state_reg != S_PULSE) |-> ((&preset_reg) && (&clear_reg)));

endmodule

// File: tb/tb_sr_latch_sequencer.sv
// Directed bench for sr_latch_sequencer: timeline model of the command protocol plus
// literal expectations, with a behavioural latch array closing the feedback loop.
module tb_sr_latch_sequencer;

  localparam int WIDE   = 17;
  localparam int IDXW   = 5;
  localparam int PULSE  = 2;
  localparam int SETTLE = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            cmd_valid;
  logic            cmd_ready;
  logic [IDXW-1:0] cmd_idx;
  logic            cmd_val;
  logic [18:1]     preset;
  logic [18:1]     clear;
  logic [1:18]     q_fb;
  logic [1:18]     qb_fb;
  logic            done;
  logic            err;
  logic [1:0]      err_code;

  logic [1:18]     arr = '0;
  logic            force_en;
  logic            fq;
  logic            fqb;

  int vectors     = 0;
  int miscompares = 0;

  sr_latch_sequencer #(.WIDE(WIDE), .IDXW(IDXW), .PULSE(PULSE), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_idx(cmd_idx), .cmd_val(cmd_val), .preset(preset), .clear(clear),
    .q_in(q_fb), .qbar_in(qb_fb), .done(done), .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  // Latch array: an active-low preset forces q=1, clear forces q=0, otherwise hold.
  always @(posedge clk) begin
    for (int i = 1; i <= 18; i++) begin
      if (!preset[i])     arr[i] <= 1'b1;
      else if (!clear[i]) arr[i] <= 1'b0;
    end
  end

  always_comb begin
    q_fb  = arr;
    qb_fb = ~arr;
    if (force_en) begin
      q_fb[5]  = fq;
      qb_fb[5] = fqb;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s t=%0t actual=%h required=%h", nm, $time, act, exp);
    end
  endtask

  function automatic logic [1:0] code_of(input logic legal, input logic q,
                                         input logic qb, input logic v);
    if (!legal)       return 2'b10;
    else if (q == qb) return 2'b11;
    else if (q != v)  return 2'b01;
    else              return 2'b00;
  endfunction

  // Protocol model: edges counted in cyc; cycle c is the period just after edge c-1.
  int         cyc = 0;
  logic       model_on = 1'b0;
  logic       busy = 1'b0;
  logic       rdy = 1'b0;
  int         t0 = 0;
  int         m_lat = 0;
  int         m_idx = 0;
  logic       m_val = 1'b0;
  logic       m_legal = 1'b0;
  logic [1:0] m_code = 2'b00;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n) begin
      model_on <= 1'b1;
      busy     <= 1'b0;
      rdy      <= 1'b0;
    end else if (busy) begin
      if (cyc + 1 == t0 + m_lat) begin
        busy <= 1'b0;
        rdy  <= 1'b1;
      end
    end else if (rdy && cmd_valid) begin
      busy    <= 1'b1;
      rdy     <= 1'b0;
      t0      <= cyc + 1;
      m_idx   <= int'(cmd_idx);
      m_val   <= cmd_val;
      m_legal <= (cmd_idx >= 5'd1) && (cmd_idx <= 5'd18);
      m_lat   <= ((cmd_idx >= 5'd1) && (cmd_idx <= 5'd18)) ? PULSE + SETTLE + 1 : 1;
      m_code  <= code_of((cmd_idx >= 5'd1) && (cmd_idx <= 5'd18),
                         (force_en && cmd_idx == 5'd5) ? fq  : cmd_val,
                         (force_en && cmd_idx == 5'd5) ? fqb : ~cmd_val,
                         cmd_val);
    end else begin
      rdy <= 1'b1;
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      int          c;
      logic        exp_low;
      logic        exp_done;
      logic [18:1] exp_p;
      logic [18:1] exp_c;
      c        = cyc + 1;
      exp_low  = busy && m_legal && (c >= t0 + 1) && (c <= t0 + PULSE);
      exp_done = busy && (c == t0 + m_lat);
      exp_p    = '1;
      exp_c    = '1;
      if (exp_low) begin
        if (m_val) exp_p[m_idx] = 1'b0;
        else       exp_c[m_idx] = 1'b0;
      end
      chk("preset", preset, exp_p);
      chk("clear", clear, exp_c);
      chk("cmd_ready", cmd_ready, rdy);
      chk("done", done, exp_done);
      chk("err", err, exp_done && (m_code != 2'b00));
      if (exp_done) chk("err_code", err_code, m_code);
    end
  end

  task automatic run_cmd(input int idx, input logic val, input int lat, input logic [1:0] code,
                         input logic [18:1] pv, input logic [18:1] cv);
    int waited = 0;
    while (cmd_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (cmd_ready !== 1'b1) begin
      vectors++;
      miscompares++;
      $display("FAIL ready_timeout idx=%0d actual=%b required=1", idx, cmd_ready);
    end
    cmd_valid = 1'b1;
    cmd_idx   = IDXW'(idx);
    cmd_val   = val;
    @(negedge clk);
    for (int k = 1; k <= lat + 1; k++) begin
      // Junk commands while busy must be ignored.
      if (k < lat) begin
        cmd_valid = 1'b1;
        cmd_idx   = 5'd19;
        cmd_val   = ~val;
      end else begin
        cmd_valid = 1'b0;
      end
      if (k <= PULSE && lat > 1) begin
        chk("lit_preset", preset, pv);
        chk("lit_clear", clear, cv);
      end
      if (k == lat) begin
        chk("lit_done", done, 1);
        chk("lit_code", err_code, code);
      end else begin
        chk("lit_done", done, 0);
      end
      if (k == lat + 1) chk("lit_ready", cmd_ready, 1);
      if (k <= lat) @(negedge clk);
    end
    $display("cmd idx=%0d val=%0d done_offset=%0d err_code=%b", idx, val, lat, code);
  endtask

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_idx   = '0;
    cmd_val   = 1'b0;
    force_en  = 1'b0;
    fq        = 1'b0;
    fqb       = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_preset", preset, 18'h3FFFF);
    chk("rst_clear", clear, 18'h3FFFF);
    chk("rst_done", done, 0);
    chk("rst_ready", cmd_ready, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_ready", cmd_ready, 1);

    run_cmd(1, 1'b1, 6, 2'b00, 18'h3FFFE, 18'h3FFFF);
    run_cmd(18, 1'b0, 6, 2'b00, 18'h3FFFF, 18'h1FFFF);
    run_cmd(0, 1'b1, 1, 2'b10, 18'h3FFFF, 18'h3FFFF);
    run_cmd(19, 1'b0, 1, 2'b10, 18'h3FFFF, 18'h3FFFF);
    run_cmd(9, 1'b1, 6, 2'b00, 18'h3FEFF, 18'h3FFFF);

    force_en = 1'b1; fq = 1'b0; fqb = 1'b1;
    run_cmd(5, 1'b1, 6, 2'b01, 18'h3FFEF, 18'h3FFFF);
    fq = 1'b1; fqb = 1'b1;
    run_cmd(5, 1'b1, 6, 2'b11, 18'h3FFEF, 18'h3FFFF);
    force_en = 1'b0;
    run_cmd(5, 1'b0, 6, 2'b00, 18'h3FFFF, 18'h3FFEF);

    // Back-to-back: valid held high for three commands.
    cmd_valid = 1'b1;
    cmd_idx   = 5'd3;
    cmd_val   = 1'b1;
    for (int j = 1; j <= 15; j++) begin
      @(negedge clk);
      chk("b2b_ready", cmd_ready, (j == 7 || j == 14));
      chk("b2b_done", done, (j == 6 || j == 13));
    end
    cmd_valid = 1'b0;
    $display("cmd b2b x3 idx=3 val=1 ready cycles 7,14");
    repeat (6) @(negedge clk);
    chk("b2b_idle", cmd_ready, 1);

    // Reset in the middle of a pulse drops the command.
    cmd_valid = 1'b1;
    cmd_idx   = 5'd7;
    cmd_val   = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("mid_pulse", preset, 18'h3FFBF);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_preset", preset, 18'h3FFFF);
    chk("mid_rst_ready", cmd_ready, 0);
    rst_n = 1'b1;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      chk("mid_rst_nodone", done, 0);
    end
    $display("cmd idx=7 val=1 aborted by reset");
    run_cmd(7, 1'b1, 6, 2'b00, 18'h3FFBF, 18'h3FFFF);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t actual=running required=finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
